// File: rtl/sram_arbiter.sv
// Two-master SRAM-like arbiter (data over inst, locked until addr_ok); zero added latency on request and response.
// Backpressure: mem_req is withheld while the in-order ID FIFO holds OUTSTANDING entries.
module sram_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  localparam int PW = (OUTSTANDING > 2) ? 2 : 1;
  localparam int CW = (OUTSTANDING > 3) ? 3 : 2;

  logic          r_lock;
  logic          r_owner;
  logic          r_arb_err;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ids [OUTSTANDING];

  logic w_grant;
  logic w_win_req;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_head;
  logic w_sel;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // 1 = data master, 0 = inst master; a pending unaccepted request pins the grant.
  assign w_grant   = r_lock ? r_owner : data_req;
  assign w_win_req = w_grant ? data_req : inst_req;
  assign w_full    = (r_count == CW'(OUTSTANDING));
  assign w_empty   = (r_count == '0);
  assign w_head    = r_ids[r_rd_ptr];

  // Gated by resetn so handshakes drop the instant reset asserts.
  assign mem_req = resetn && w_win_req && !w_full;
  assign w_push  = mem_req && mem_addr_ok;
  assign w_pop   = mem_data_ok && !w_empty;

  assign w_sel     = mem_req ? w_grant : 1'b1;
  assign mem_wr    = w_sel ? data_wr    : inst_wr;
  assign mem_size  = w_sel ? data_size  : inst_size;
  assign mem_addr  = w_sel ? data_addr  : inst_addr;
  assign mem_wstrb = w_sel ? data_wstrb : inst_wstrb;
  assign mem_wdata = w_sel ? data_wdata : inst_wdata;

  assign inst_addr_ok = w_push && !w_grant;
  assign data_addr_ok = w_push &&  w_grant;
  assign inst_data_ok = resetn && w_pop && !w_head;
  assign data_data_ok = resetn && w_pop &&  w_head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign arb_err      = r_arb_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lock    <= 1'b0;
      r_owner   <= 1'b0;
      r_arb_err <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      for (int i = 0; i < OUTSTANDING; i++) r_ids[i] <= 1'b0;
    end else begin
      if (mem_req && !mem_addr_ok) begin
        r_lock  <= 1'b1;
        r_owner <= w_grant;
      end else if (mem_addr_ok) begin
        r_lock <= 1'b0;
      end
      if (w_push) begin
        r_ids[r_wr_ptr] <= w_grant;
        r_wr_ptr        <= f_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (mem_data_ok && w_empty) r_arb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        arb_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.OUTSTANDING(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .arb_err(arb_err)
  );

  // Advance to 1ns after the next rising edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Move to the sampling point (negedge) of the current cycle.
  task automatic sample();
    #4;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    #2;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin failures++; $display("FAIL reset_addr_ok got=%b exp=00", {inst_addr_ok, data_addr_ok}); end
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL reset_data_ok got=%b exp=00", {inst_data_ok, data_data_ok}); end
    checks++; if (arb_err !== 1'b0) begin failures++; $display("FAIL reset_arb_err got=%b exp=0", arb_err); end
    idle_inputs();
    next_cycle();
    next_cycle();
    resetn = 1;
  endtask

  task automatic test_single_inst();
    inst_req = 1; inst_addr = 32'h1C000000; mem_addr_ok = 1;
    sample();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1C000000) begin failures++; $display("FAIL single_req got req=%b addr=%h exp 1 1c000000", mem_req, mem_addr); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin failures++; $display("FAIL single_addr_ok got=%b exp=10", {inst_addr_ok, data_addr_ok}); end
    next_cycle();
    inst_req = 0; mem_addr_ok = 0;
    sample();
    checks++; if ({mem_req, inst_data_ok, data_data_ok} !== 3'b000) begin failures++; $display("FAIL single_gap got=%b exp=000", {mem_req, inst_data_ok, data_data_ok}); end
    next_cycle();
    mem_data_ok = 1; mem_rdata = 32'h02C00000;
    sample();
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL single_data_ok got=%b exp=10", {inst_data_ok, data_data_ok}); end
    checks++; if (inst_rdata !== 32'h02C00000) begin failures++; $display("FAIL single_rdata got=%h exp=02c00000", inst_rdata); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_contention();
    inst_req = 1; inst_addr = 32'h200;
    data_req = 1; data_wr = 1; data_addr = 32'h100; data_wstrb = 4'hF; data_wdata = 32'hDEADBEEF;
    mem_addr_ok = 1;
    sample();
    checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin failures++; $display("FAIL cont_first got=%b exp=10", {data_addr_ok, inst_addr_ok}); end
    checks++; if (mem_addr !== 32'h100 || mem_wr !== 1'b1 || mem_wstrb !== 4'hF || mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL cont_mux got addr=%h wr=%b strb=%h wd=%h exp 100 1 f deadbeef", mem_addr, mem_wr, mem_wstrb, mem_wdata); end
    next_cycle();
    data_req = 0;
    sample();
    checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b01 || mem_addr !== 32'h200 || mem_wr !== 1'b0) begin failures++; $display("FAIL cont_second got ok=%b addr=%h wr=%b exp 01 200 0", {data_addr_ok, inst_addr_ok}, mem_addr, mem_wr); end
    next_cycle();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11111111;
    sample();
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b10 || data_rdata !== 32'h11111111) begin failures++; $display("FAIL cont_ret1 got ok=%b rd=%h exp 10 11111111", {data_data_ok, inst_data_ok}, data_rdata); end
    next_cycle();
    mem_rdata = 32'h22222222;
    sample();
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b01 || inst_rdata !== 32'h22222222) begin failures++; $display("FAIL cont_ret2 got ok=%b rd=%h exp 01 22222222", {data_data_ok, inst_data_ok}, inst_rdata); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_lock();
    inst_req = 1; inst_addr = 32'h300; mem_addr_ok = 0;
    sample();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 || inst_addr_ok !== 1'b0) begin failures++; $display("FAIL lock_c0 got req=%b addr=%h ok=%b exp 1 300 0", mem_req, mem_addr, inst_addr_ok); end
    for (int c = 1; c < 3; c++) begin
      next_cycle();
      data_req = 1; data_addr = 32'h400;
      sample();
      checks++; if (mem_addr !== 32'h300 || {inst_addr_ok, data_addr_ok} !== 2'b00) begin failures++; $display("FAIL lock_hold%0d got addr=%h ok=%b exp 300 00", c, mem_addr, {inst_addr_ok, data_addr_ok}); end
    end
    next_cycle();
    mem_addr_ok = 1;
    sample();
    checks++; if (mem_addr !== 32'h300 || {inst_addr_ok, data_addr_ok} !== 2'b10) begin failures++; $display("FAIL lock_release got addr=%h ok=%b exp 300 10", mem_addr, {inst_addr_ok, data_addr_ok}); end
    next_cycle();
    inst_req = 0;
    sample();
    checks++; if (mem_addr !== 32'h400 || {inst_addr_ok, data_addr_ok} !== 2'b01) begin failures++; $display("FAIL lock_after got addr=%h ok=%b exp 400 01", mem_addr, {inst_addr_ok, data_addr_ok}); end
    next_cycle();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    sample();
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL lock_ret1 got=%b exp=10", {inst_data_ok, data_data_ok}); end
    next_cycle();
    sample();
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin failures++; $display("FAIL lock_ret2 got=%b exp=01", {inst_data_ok, data_data_ok}); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_full();
    inst_req = 1; mem_addr_ok = 1;
    for (int k = 0; k < 2; k++) begin
      inst_addr = 32'h500 + 32'(4 * k);
      sample();
      checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL full_fill%0d got=%b exp=1", k, inst_addr_ok); end
      next_cycle();
    end
    inst_addr = 32'h508;
    sample();
    checks++; if ({mem_req, inst_addr_ok} !== 2'b00) begin failures++; $display("FAIL full_block got=%b exp=00", {mem_req, inst_addr_ok}); end
    next_cycle();
    mem_data_ok = 1;
    sample();
    checks++; if ({mem_req, inst_addr_ok, inst_data_ok} !== 3'b001) begin failures++; $display("FAIL full_pop_block got=%b exp=001", {mem_req, inst_addr_ok, inst_data_ok}); end
    next_cycle();
    sample();
    checks++; if ({mem_req, inst_addr_ok, inst_data_ok} !== 3'b111) begin failures++; $display("FAIL full_pushpop got=%b exp=111", {mem_req, inst_addr_ok, inst_data_ok}); end
    next_cycle();
    mem_data_ok = 0; inst_addr = 32'h50C;
    sample();
    checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL full_count1 got=%b exp=1", inst_addr_ok); end
    next_cycle();
    inst_addr = 32'h510;
    sample();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL full_count2 got=%b exp=0", mem_req); end
    next_cycle();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int k = 0; k < 2; k++) begin
      sample();
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL full_drain%0d got=%b exp=10", k, {inst_data_ok, data_data_ok}); end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_spurious();
    sample();
    checks++; if (arb_err !== 1'b0) begin failures++; $display("FAIL spur_pre got=%b exp=0", arb_err); end
    next_cycle();
    mem_data_ok = 1; mem_rdata = 32'hBAD0BAD0;
    sample();
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL spur_data_ok got=%b exp=00", {inst_data_ok, data_data_ok}); end
    next_cycle();
    mem_data_ok = 0;
    sample();
    checks++; if (arb_err !== 1'b1) begin failures++; $display("FAIL spur_set got=%b exp=1", arb_err); end
    next_cycle(); next_cycle();
    sample();
    checks++; if (arb_err !== 1'b1) begin failures++; $display("FAIL spur_sticky got=%b exp=1", arb_err); end
    next_cycle();
  endtask

  task automatic test_async_reset();
    inst_req = 1; inst_addr = 32'h600; mem_addr_ok = 1;
    next_cycle();
    next_cycle();
    mem_data_ok = 1;
    #2;
    resetn = 0;
    #1;
    checks++; if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b000) begin failures++; $display("FAIL areset_req got=%b exp=000", {mem_req, inst_addr_ok, data_addr_ok}); end
    checks++; if ({inst_data_ok, data_data_ok, arb_err} !== 3'b000) begin failures++; $display("FAIL areset_ok got=%b exp=000", {inst_data_ok, data_data_ok, arb_err}); end
    next_cycle();
    resetn = 1; inst_req = 0; mem_addr_ok = 0;
    sample();
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL areset_late got=%b exp=00", {inst_data_ok, data_data_ok}); end
    next_cycle();
    mem_data_ok = 0; inst_req = 1; mem_addr_ok = 0;
    sample();
    checks++; if (arb_err !== 1'b1 || mem_req !== 1'b1) begin failures++; $display("FAIL areset_after got err=%b req=%b exp 1 1", arb_err, mem_req); end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_inst();
    test_contention();
    test_lock();
    test_full();
    test_spurious();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-master, one-slave arbiter for the SRAM-like memory interface (req/addr_ok/data_ok split handshake).
- Shares a single memory port between the instruction-fetch requester (IF stage) and the data requester (EX issues, MEM collects data_ok).
- Sits between the pipeline and the memory bridge.
- Tracks outstanding transactions in order so each data_ok/rdata returns to the master that issued the request.

Parameters:
- OUTSTANDING, 2, maximum accepted-but-not-returned transactions (2..4); depth of the ID FIFO.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  IF request valid
- inst_wr  in  1  IF write (tied 0 in practice; passed through)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  IF address
- inst_wstrb  in  4  IF byte strobes
- inst_wdata  in  32  IF write data
- inst_addr_ok  out  1  IF request accepted
- inst_data_ok  out  1  IF transaction completed
- inst_rdata  out  32  IF read data
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  1/1/2/32/4/32  same meaning, data master
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data transaction completed
- data_rdata  out  32  data read data
- mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata  out  1/1/2/32/4/32  to slave
- mem_addr_ok  in  1  slave accepted
- mem_data_ok  in  1  slave completed (in order)
- mem_rdata  in  32  slave read data
- arb_err  out  1  sticky: data_ok received with no outstanding transaction

Behaviour:
- Reset (resetn=0, async): FIFO count=0, rd/wr pointers=0, lock=0, owner=0, arb_err=0. All handshake outputs are combinational from these, so they read 0 during reset.
- Grant select, when lock=0:
  - data_req=1 → data wins.
  - else inst_req=1 → inst wins.
  - Data has fixed priority.
- Lock:
  - If the winner's req is driven to the slave and mem_addr_ok=0, set lock=1 and owner=winner at the clock edge.
  - While lock=1, grant=owner regardless of the other req.
  - Clear lock on the cycle mem_addr_ok=1.
  - Guarantees the slave sees a stable request (SRAM-like rule).
- Full: full = (count==OUTSTANDING). mem_req = (granted master's req) && !full.
- Request mux: mem_wr/size/addr/wstrb/wdata = granted master's fields. They are don't-care when mem_req=0; drive data master's fields.
- Accept: X_addr_ok = mem_addr_ok && mem_req && grant==X. It is never asserted to the non-granted master.
- Push: on mem_req && mem_addr_ok, write grant ID (1=data, 0=inst) at wr pointer, wr pointer+1 mod OUTSTANDING, count+1.
- Pop: on mem_data_ok && count!=0:
  - head ID selects the destination.
  - X_data_ok=1 for that master only, same cycle, combinational.
  - Both rdata outputs = mem_rdata.
  - rd pointer+1 mod OUTSTANDING, count-1.
- Simultaneous push and pop: both happen, count unchanged, pointers both advance. A push is still blocked when full at the start of the cycle, even if a pop occurs that cycle.
- Spurious completion: mem_data_ok with count==0 → no data_ok asserted to either master, arb_err set to 1. arb_err is cleared only by reset.
- Latency:
  - 0 cycles added to request and response paths (pure combinational forwarding).
  - Accept-to-data_ok latency equals the slave's.
- Pointer wrap: pointers wrap from OUTSTANDING-1 to 0. count is never >OUTSTANDING nor <0.
- Reset mid-transaction: all tracking is discarded. Late data_ok after reset counts as spurious (arb_err).

Test Plan:
- Single inst read: inst_req=1 addr 0x1C000000, slave addr_ok in cycle 0, data_ok+rdata 0x02C00000 in cycle 2 → inst_addr_ok cycle 0, inst_data_ok cycle 2 with inst_rdata 0x02C00000, data_* outputs stay 0.
- Contention: inst_req and data_req (store, addr 0x100, wstrb 0xF) both high, slave addr_ok=1 → data accepted first, then inst next cycle; data_ok returns to data, then to inst, in order.
- Lock: inst_req alone, slave addr_ok=0 for 3 cycles, data_req rises in cycle 1 → mem_addr stays inst's until addr_ok; data is granted only after.
- Full (OUTSTANDING=2): 2 accepts without data_ok → mem_req=0, no addr_ok while the 3rd request waits. One data_ok frees a slot; the 3rd request is accepted the following cycle. Same-cycle push+pop when count=1 keeps count=1.
- Spurious: mem_data_ok=1 with count=0 → inst_data_ok=data_data_ok=0, arb_err=1 and stays 1.
- Async reset: assert resetn=0 mid-cycle with count=2 → outputs drop immediately, count=0, lock=0, arb_err=0.
